// File: rtl/cypher_tx_fifo_if.sv
// Byte-stream handshake between the ChaCha core, the transmit FIFO and the SPI slave.
// master = core/SPI side, slave = FIFO side.
interface cypher_tx_fifo_if;
  logic [7:0] io_cyphertext;
  logic       io_cypher_valid;
  logic       io_cypher_ready;
  logic       o_RX_DV;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;

  modport master (
    output io_cyphertext, io_cypher_valid, o_RX_DV,
    input  io_cypher_ready, i_TX_DV, i_TX_Byte
  );

  modport slave (
    input  io_cyphertext, io_cypher_valid, o_RX_DV,
    output io_cypher_ready, i_TX_DV, i_TX_Byte
  );
endinterface

// File: rtl/cypher_tx_fifo.sv
// Cyphertext byte FIFO feeding the SPI slave transmit register, with FILL_BYTE on empty.
// Optional macro CYPHER_TX_UNDERRUN_CNT_EN adds a saturating underrun counter port.
module cypher_tx_fifo #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] FILL_BYTE = 8'hA5,
  localparam int        CW        = $clog2(DEPTH) + 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  cypher_tx_fifo_if.slave         io_bus,
  input  logic                    i_Flush,
  output logic [CW-1:0]           o_Count,
  output logic                    o_Underrun
`ifdef CYPHER_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]              o_Underrun_Cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_pending;
  logic            w_pend_next;
  logic            r_tx_dv;
  logic [7:0]      r_tx_byte;
  logic            r_underrun;
  logic            w_load_go;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_underrun_next;

  assign io_bus.io_cypher_ready = (r_count != CW'(DEPTH)) && !i_Flush && !i_Rst;
  assign w_push          = io_bus.io_cypher_valid && io_bus.io_cypher_ready;
  assign w_empty         = (r_count == '0);
  assign w_pop           = w_load_go && !w_empty;
  // The preload out of IDLE is expected to find an empty FIFO and is not an underrun.
  assign w_underrun_next = w_load_go && w_empty && (r_state == ARMED);

  assign io_bus.i_TX_DV   = r_tx_dv;
  assign io_bus.i_TX_Byte = r_tx_byte;
  assign o_Count          = r_count;
  assign o_Underrun       = r_underrun;

  always_comb begin
    w_next      = r_state;
    w_load_go   = 1'b0;
    w_pend_next = r_pending;
    case (r_state)
      IDLE: begin
        w_next    = LOAD;
        w_load_go = 1'b1;
        if (io_bus.o_RX_DV) w_pend_next = 1'b1;
      end
      LOAD: begin
        w_next = ARMED;
        if (io_bus.o_RX_DV) w_pend_next = 1'b1;
      end
      ARMED: begin
        if (io_bus.o_RX_DV || r_pending) begin
          w_next      = LOAD;
          w_load_go   = 1'b1;
          // A fresh request arriving while a pending one is consumed stays pending.
          w_pend_next = r_pending && io_bus.o_RX_DV;
        end
      end
      default: w_next = IDLE;
    endcase
    if (i_Flush) begin
      w_next      = IDLE;
      w_load_go   = 1'b0;
      w_pend_next = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_push) r_mem[r_wptr] <= io_bus.io_cyphertext;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state    <= IDLE;
      r_pending  <= 1'b0;
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_underrun <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_pending  <= w_pend_next;
      r_tx_dv    <= w_load_go;
      r_underrun <= w_underrun_next;
      if (w_load_go) r_tx_byte <= w_empty ? FILL_BYTE : r_mem[r_rptr];
      if (i_Flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef CYPHER_TX_UNDERRUN_CNT_EN
  logic [7:0] r_underrun_cnt;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_underrun_cnt <= 8'h00;
    end else if (i_Flush) begin
      r_underrun_cnt <= 8'h00;
    end else if (w_underrun_next && (r_underrun_cnt != 8'hFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 8'h01;
    end
  end

  assign o_Underrun_Cnt = r_underrun_cnt;
`endif

endmodule
